mskaes_ks_round_ctrl: RTL and testbench
=======================================

Name: mskaes_ks_round_ctrl

Overview:
- Control FSM for the 32-bit-per-cycle masked AES-128 key schedule.
- Directly drives the round-constant generator: rcon_init feeds its reset, rcon_update feeds its update, rcon_mask feeds its output gate.
- Sequences the shared key column register file and the shared S-box word path, one key-schedule round per request from the encryption datapath.
- Supports forward (encryption) and inverse (decryption) key expansion; moves no share data itself, so it is share-count agnostic.

Parameters:
- SBOX_LAT, 4, cycles from sb_feed to the S-box result being valid; must be >= 1.
- NROUNDS, 10, number of key-schedule rounds per run.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin key load plus expansion; sampled only in IDLE
- inverse  in  1  direction; latched at accepted start
- round_req  in  1  level request for the next round key
- round_ack  out  1  one-cycle pulse: round key updated
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse coincident with the last round_ack
- key_load  out  1  column write selects the external key input
- col_we  out  1  column register write enable
- col_sel  out  2  column index written this cycle
- col_use_sb  out  1  column 0 update XORs the S-box word
- sb_feed  out  1  issue RotWord(col3) to the S-box
- rcon_init  out  1  drives the rcon generator reset
- rcon_update  out  1  advance rcon
- rcon_mask  out  1  rcon sharing enabled (non-zero)
- round_cnt  out  4  completed rounds, 0..NROUNDS
- last_round  out  1  round_cnt == NROUNDS-1

Behaviour:
- Reset state:
  - State is IDLE.
  - All outputs are 0, round_cnt is 0, the latched inverse is 0.
  - Reset has priority in every state; a run aborted mid-round emits no ack and no done.
- States: IDLE, LOAD, WAIT_REQ, PRE (inverse only), FEED, SBWAIT, UPD, ACK.
- IDLE:
  - On start: latch inverse, clear round_cnt, go to LOAD.
  - start while busy is ignored.
- LOAD (4 cycles):
  - key_load=1, col_we=1, col_sel=0,1,2,3 in successive cycles.
  - rcon_init=1 throughout.
  - Then go to WAIT_REQ.
- WAIT_REQ:
  - round_req=1 moves to FEED when forward, PRE when inverse.
  - A request asserted in any other state is held by the requester and accepted on WAIT_REQ entry.
- Forward round (accept cycle = 0):
  - FEED at cycle 1 (sb_feed=1).
  - SBWAIT for SBOX_LAT-1 cycles.
  - Cycle SBOX_LAT+1: col_we, col_sel=0, col_use_sb=1, rcon_mask=1.
  - Cycles SBOX_LAT+2..+4: col_sel=1,2,3 (col_i ^= new col_{i-1}).
  - Cycle SBOX_LAT+5: ACK.
- Inverse round (accept cycle = 0):
  - PRE cycles 1..3: col_we, col_sel=3,2,1 (col_i ^= col_{i-1}).
  - FEED at cycle 4.
  - Cycle 4+SBOX_LAT: col_sel=0, col_use_sb=1, rcon_mask=1.
  - Cycle 5+SBOX_LAT: ACK.
- rcon_mask is high only in the col_use_sb cycle; elsewhere the rcon sharing is zero.
- ACK (1 cycle):
  - round_ack=1, rcon_update=1, round_cnt increments.
  - If the new count equals NROUNDS: done=1, go to IDLE; otherwise go to WAIT_REQ.
- SBWAIT counter:
  - Width clog2(SBOX_LAT+1); loaded at FEED, counts down, no wrap.
  - With SBOX_LAT=1, SBWAIT is skipped.
- round_cnt holds its value in IDLE after done until the next start.
- inverse changes after start have no effect until the next run.

Decomposition:
- Shared package mskaes_ks_pkg holds:
  - State encoding enum.
  - Column index constants COL0..COL3.
  - Round count width constant.
- One sub-module: mskaes_ks_latcnt, a loadable down-counter with zero flag, used for SBWAIT.

Test Plan:
- Forward, SBOX_LAT=4:
  - start, then round_req held high.
  - LOAD col_sel 0..3 with rcon_init high.
  - First round: sb_feed at accept+1; col_sel=0 with col_use_sb=1 and rcon_mask=1 at accept+5; col3 at accept+8; round_ack plus rcon_update at accept+9.
- Inverse, SBOX_LAT=4:
  - col_sel=3,2,1 at accept+1..3, sb_feed at accept+4.
  - col0 with rcon_mask at accept+8, ack at accept+9.
- Full run, NROUNDS=10:
  - Exactly 10 round_ack pulses and 10 rcon_update pulses.
  - done coincides with the 10th ack; round_cnt=10; busy falls the next cycle.
  - last_round high only while round_cnt=9.
- round_req low for 7 cycles after an ack: FSM stays in WAIT_REQ with all strobes 0, and resumes on assertion.
- Reset asserted in SBWAIT of round 3:
  - Next cycle IDLE, all outputs 0, round_cnt=0, no ack.
  - A fresh start then runs normally.
- start pulsed while busy: ignored, with no LOAD restart. SBOX_LAT=1: sb_feed is immediately followed by the col0 update cycle.

Source files
------------

// File: rtl/mskaes_ks_pkg.sv
// Shared definitions for the masked AES-128 key-schedule control slice:
// FSM state encoding, key column indices and the round counter width.
package mskaes_ks_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_WAIT_REQ = 3'd2,
    ST_PRE      = 3'd3,
    ST_FEED     = 3'd4,
    ST_SBWAIT   = 3'd5,
    ST_UPD      = 3'd6,
    ST_ACK      = 3'd7
  } ks_state_e;

  localparam logic [1:0] COL0 = 2'd0;
  localparam logic [1:0] COL1 = 2'd1;
  localparam logic [1:0] COL2 = 2'd2;
  localparam logic [1:0] COL3 = 2'd3;

  localparam int RCNT_W = 4;

endpackage

// File: rtl/mskaes_ks_latcnt.sv
// Loadable down-counter with a zero flag; times the S-box latency wait.
// Saturates at zero instead of wrapping.
module mskaes_ks_latcnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mskaes_ks_round_ctrl.sv
// Control FSM for the 32-bit-per-cycle masked AES-128 key schedule. Sequences
// key load, forward/inverse round updates, the shared S-box word and rcon.
module mskaes_ks_round_ctrl
  import mskaes_ks_pkg::*;
#(
  parameter int SBOX_LAT = 4,
  parameter int NROUNDS  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              inverse,
  input  logic              round_req,
  output logic              round_ack,
  output logic              busy,
  output logic              done,
  output logic              key_load,
  output logic              col_we,
  output logic [1:0]        col_sel,
  output logic              col_use_sb,
  output logic              sb_feed,
  output logic              rcon_init,
  output logic              rcon_update,
  output logic              rcon_mask,
  output logic [RCNT_W-1:0] round_cnt,
  output logic              last_round
);

  // Handshake: round_req is a level request that the requester holds until
  // round_ack. It is sampled only in WAIT_REQ; each accepted request yields
  // exactly one single-cycle round_ack once the round key is fully updated.

  localparam int LAT_W = $clog2(SBOX_LAT + 1);
  // SBWAIT runs while the counter walks LAT_LOAD..0, i.e. SBOX_LAT-1 cycles.
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'((SBOX_LAT > 1) ? SBOX_LAT - 2 : 0);
  localparam logic [RCNT_W-1:0] LAST_CNT = RCNT_W'(NROUNDS - 1);

  ks_state_e         state_q, state_d;
  logic [1:0]        col_q, col_d;
  logic              inv_q;
  logic [RCNT_W-1:0] cnt_q;
  logic              cnt_clr, cnt_inc;
  logic              lat_load, lat_dec, lat_zero;
  logic [LAT_W-1:0]  lat_cnt;

  mskaes_ks_latcnt #(
    .W (LAT_W)
  ) u_latcnt (
    .clk      (clk),
    .rst      (rst),
    .load     (lat_load),
    .load_val (LAT_LOAD),
    .dec      (lat_dec),
    .cnt      (lat_cnt),
    .zero     (lat_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      col_q   <= COL0;
      inv_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      if (cnt_clr) begin
        inv_q <= inverse;
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    lat_load    = 1'b0;
    lat_dec     = 1'b0;
    round_ack   = 1'b0;
    done        = 1'b0;
    key_load    = 1'b0;
    col_we      = 1'b0;
    col_sel     = COL0;
    col_use_sb  = 1'b0;
    sb_feed     = 1'b0;
    rcon_init   = 1'b0;
    rcon_update = 1'b0;
    rcon_mask   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_clr = 1'b1;
          col_d   = COL0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        key_load  = 1'b1;
        col_we    = 1'b1;
        col_sel   = col_q;
        rcon_init = 1'b1;
        col_d     = col_q + 2'd1;
        if (col_q == COL3) state_d = ST_WAIT_REQ;
      end
      ST_WAIT_REQ: begin
        if (round_req) begin
          if (inv_q) begin
            col_d   = COL3;
            state_d = ST_PRE;
          end else begin
            state_d = ST_FEED;
          end
        end
      end
      // Inverse rounds first undo the col_i ^= col_{i-1} chain, top down,
      // so that col3 holds the previous round's value before RotWord.
      ST_PRE: begin
        col_we  = 1'b1;
        col_sel = col_q;
        col_d   = col_q - 2'd1;
        if (col_q == COL1) state_d = ST_FEED;
      end
      ST_FEED: begin
        sb_feed  = 1'b1;
        lat_load = 1'b1;
        col_d    = COL0;
        state_d  = (SBOX_LAT == 1) ? ST_UPD : ST_SBWAIT;
      end
      ST_SBWAIT: begin
        lat_dec = 1'b1;
        if (lat_zero) state_d = ST_UPD;
      end
      ST_UPD: begin
        col_we     = 1'b1;
        col_sel    = col_q;
        col_use_sb = (col_q == COL0);
        rcon_mask  = (col_q == COL0);
        col_d      = col_q + 2'd1;
        if (inv_q || (col_q == COL3)) state_d = ST_ACK;
      end
      ST_ACK: begin
        round_ack   = 1'b1;
        rcon_update = 1'b1;
        cnt_inc     = 1'b1;
        if (cnt_q == LAST_CNT) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign round_cnt  = cnt_q;
  assign last_round = (cnt_q == LAST_CNT);

endmodule

// File: tb/tb_mskaes_ks_round_ctrl.sv
// Bench for mskaes_ks_round_ctrl: two instances (S-box latency 4 and 1) share
// stimulus; each is checked cycle by cycle against a trace built from round timing.
module tb_mskaes_ks_round_ctrl;

  localparam int NR = 10;

  logic clk = 1'b0;
  logic rst, start, inverse, round_req;
  logic req_rand;
  int   n_tests = 0;
  int   n_fail  = 0;

  wire [1:0] busy_v, feed_v, ack_v;
  wire [7:0] cnt_v;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {busy, ack, done, key_load, col_we, col_sel[1:0], col_use_sb, sb_feed,
  //  rcon_init, rcon_update, rcon_mask, last_round, round_cnt[3:0]}
  function automatic logic [16:0] mk(input int busy, input int ack, input int dn,
                                     input int kl, input int we, input int sel,
                                     input int usb, input int feed, input int ri,
                                     input int ru, input int rm, input int c);
    logic last;
    last = (c == NR - 1);
    return {busy[0], ack[0], dn[0], kl[0], we[0], sel[1:0], usb[0], feed[0],
            ri[0], ru[0], rm[0], last, c[3:0]};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 4 : 1;

    logic       round_ack, busy, done, key_load, col_we, col_use_sb, sb_feed;
    logic       rcon_init, rcon_update, rcon_mask, last_round;
    logic [1:0] col_sel;
    logic [3:0] round_cnt;

    mskaes_ks_round_ctrl #(
      .SBOX_LAT (LAT),
      .NROUNDS  (NR)
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .inverse     (inverse),
      .round_req   (round_req),
      .round_ack   (round_ack),
      .busy        (busy),
      .done        (done),
      .key_load    (key_load),
      .col_we      (col_we),
      .col_sel     (col_sel),
      .col_use_sb  (col_use_sb),
      .sb_feed     (sb_feed),
      .rcon_init   (rcon_init),
      .rcon_update (rcon_update),
      .rcon_mask   (rcon_mask),
      .round_cnt   (round_cnt),
      .last_round  (last_round)
    );

    assign busy_v[g]         = busy;
    assign feed_v[g]         = sb_feed;
    assign ack_v[g]          = round_ack;
    assign cnt_v[g*4 +: 4]   = round_cnt;

    logic [16:0] exp_q[$];
    logic [16:0] e, obs;
    bit          running, inv_m, known;
    int          cnt_m, acks;

    // Reference: idle / waiting cycles are derived from the run status; each
    // accepted round or start pushes its whole cycle trace onto exp_q.
    always @(negedge clk) begin
      obs = {busy, round_ack, done, key_load, col_we, col_sel, col_use_sb, sb_feed,
             rcon_init, rcon_update, rcon_mask, last_round, round_cnt};
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e[15]) begin
          acks++;
          cnt_m++;
          if (cnt_m == NR) running = 1'b0;
        end
      end else if (running) begin
        e = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cnt_m);
        if (round_req) begin
          if (!inv_m) begin
            exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, cnt_m));
            for (int p = 2; p <= LAT; p++) exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cnt_m));
            for (int k = 0; k < 4; k++)
              exp_q.push_back(mk(1, 0, 0, 0, 1, k, (k == 0), 0, 0, 0, (k == 0), cnt_m));
          end else begin
            for (int k = 3; k >= 1; k--) exp_q.push_back(mk(1, 0, 0, 0, 1, k, 0, 0, 0, 0, 0, cnt_m));
            exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, cnt_m));
            for (int p = 2; p <= LAT; p++) exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cnt_m));
            exp_q.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, cnt_m));
          end
          exp_q.push_back(mk(1, 1, (cnt_m + 1 == NR), 0, 0, 0, 0, 0, 0, 1, 0, cnt_m));
        end
      end else begin
        e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cnt_m);
        if (start) begin
          running = 1'b1;
          inv_m   = inverse;
          cnt_m   = 0;
          acks    = 0;
          for (int k = 0; k < 4; k++) exp_q.push_back(mk(1, 0, 0, 1, 1, k, 0, 0, 1, 0, 0, 0));
        end
      end
      if (known) begin
        check($sformatf("lane%0d_trace@%0t", g, $time), 32'(obs), 32'(e));
        if (e[14]) check($sformatf("lane%0d_acks_at_done", g), 32'(acks), 32'(NR));
      end
      if (rst) begin
        exp_q.delete();
        running = 1'b0;
        inv_m   = 1'b0;
        cnt_m   = 0;
        known   = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (req_rand) begin
      #1;
      round_req = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit inv);
    start   = 1'b1;
    inverse = inv;
    cyc();
    start   = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit noise);
    int k;
    k = 0;
    while (busy_v != 2'b00 && k < budget) begin
      if (noise) begin
        start   = (busy_v == 2'b11) && ($urandom_range(0, 15) == 0);
        inverse = 1'($urandom_range(0, 1));
      end
      cyc();
      k++;
    end
    start = 1'b0;
    check("run_finished", 32'(busy_v), 32'd0);
  endtask

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; inverse = 1'b0; round_req = 1'b0; req_rand = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    // Forward run, request held high.
    round_req = 1'b1;
    pulse_start(1'b0);
    wait_idle(2000, 1'b0);
    round_req = 1'b0;
    repeat (3) cyc();

    // Inverse run; inverse toggles and start pulses arrive while busy.
    round_req = 1'b1;
    pulse_start(1'b1);
    wait_idle(2000, 1'b1);

    // Request withdrawn for 7 cycles after the first lane-0 ack.
    round_req = 1'b1;
    pulse_start(1'b0);
    k = 0;
    while (!ack_v[0] && k < 200) begin cyc(); k++; end
    check("first_ack_seen", 32'(k < 200), 32'd1);
    round_req = 1'b0;
    repeat (8) cyc();
    round_req = 1'b1;
    wait_idle(2000, 1'b0);

    // Abort during the S-box wait of round 3, then a fresh run.
    round_req = 1'b1;
    pulse_start(1'b0);
    k = 0;
    while (!(feed_v[0] && cnt_v[3:0] == 4'd2) && k < 500) begin cyc(); k++; end
    check("round3_feed_seen", 32'(k < 500), 32'd1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("abort_busy", 32'(busy_v[0]), 32'd0);
    check("abort_cnt", 32'(cnt_v[3:0]), 32'd0);
    pulse_start(1'b0);
    wait_idle(2000, 1'b0);

    // Randomized runs: random direction, random request gaps, noise on start.
    req_rand = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pulse_start(1'($urandom_range(0, 1)));
      wait_idle(4000, 1'b1);
      repeat (2) cyc();
    end
    req_rand = 1'b0;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
